mult_controller: RTL

//  Control FSM for the shift-add multiplier datapath.
//  - Datapath: multiplicand reg shifts left, multiplier reg shifts right, product accumulates.
//  - Sequences Load, Add and Shift strobes and owns the iteration counter.
//  - Reports Busy/Done to the CPU mult/div unit, which issues Start.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/mult_iter_counter.sv | 31 +++
 rtl/mult_controller.sv | 104 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier controller: state encoding,
// default operand width and iteration-counter width helper.
package mult_pkg;

  localparam int unsigned MULT_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } mult_state_e;

  // Bits needed to hold the iteration count 0..w
  function automatic int unsigned iter_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiplier: parallel load, saturating decrement,
// and a look-ahead flag for the decrement that reaches zero.
module mult_iter_counter #(
  parameter int unsigned CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count,
  output logic          zero_next
);

  logic [CW-1:0] count_q;

  // Load has priority; decrement holds at zero instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign count     = count_q;
  assign zero_next = (count_q == CW'(1)) & dec;

endmodule

// File: rtl/mult_controller.sv
// Control FSM for the shift-add multiplier datapath (Load/Add/Shift strobes,
// Busy/Done handshake). Define EARLY_TERM_EN to finish as soon as the multiplier is zero.
module mult_controller
  import mult_pkg::*;
#(
  parameter  int unsigned WIDTH = MULT_WIDTH_DEF,
  localparam int unsigned IW    = iter_w(WIDTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Mplier_lsb,
  input  logic          Mplier_zero,
  output logic          Load,
  output logic          Add,
  output logic          Shift,
  output logic          Busy,
  output logic          Done,
  output logic [IW-1:0] Iter
);

  mult_state_e   state_q, state_d;
  logic          early_term_c;
  logic          load_q, add_en_q, shift_q, busy_q, done_q;
  logic          cnt_load_c, cnt_dec_c, cnt_zero_next;
  logic [IW-1:0] cnt_val_c, cnt;

  // Next-state decode
  always_comb begin
    state_d      = state_q;
    early_term_c = 1'b0;
    case (state_q)
      IDLE:  if (Start) state_d = LOAD;
      LOAD:  state_d = ADD;
      ADD: begin
`ifdef EARLY_TERM_EN
        if (Mplier_zero) begin
          state_d      = DONE;
          early_term_c = 1'b1;
        end else begin
          state_d = SHIFT;
        end
`else
        state_d = SHIFT;
`endif
      end
      SHIFT: state_d = cnt_zero_next ? DONE : ADD;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State plus per-state output flags, registered from the next state
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      load_q   <= 1'b0;
      add_en_q <= 1'b0;
      shift_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      load_q   <= (state_d == LOAD);
      add_en_q <= (state_d == ADD);
      shift_q  <= (state_d == SHIFT);
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
    end
  end

  // Early exit clears the count so Iter reads 0 in DONE/IDLE
  assign cnt_load_c = (state_q == LOAD) | early_term_c;
  assign cnt_val_c  = (state_q == LOAD) ? IW'(WIDTH) : '0;
  assign cnt_dec_c  = (state_q == SHIFT);

  mult_iter_counter #(
    .CW(IW)
  ) u_iter_counter (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (cnt_load_c),
    .dec      (cnt_dec_c),
    .load_val (cnt_val_c),
    .count    (cnt),
    .zero_next(cnt_zero_next)
  );

  // Add must follow the live multiplier LSB, so it is gated combinationally
`ifdef EARLY_TERM_EN
  assign Add = add_en_q & Mplier_lsb & ~Mplier_zero;
`else
  assign Add = add_en_q & Mplier_lsb;
  logic unused_mplier_zero;
  assign unused_mplier_zero = Mplier_zero;
`endif

  assign Load  = load_q;
  assign Shift = shift_q;
  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Iter  = cnt;

endmodule
